// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Lane/extend helpers assume a 32-bit word split into four byte lanes.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int LAT_CNT_W = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } dmem_req_t;

  // Lane forced to natural alignment for the access size.
  function automatic logic [1:0] lane_of(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [1:0] l;
    l = 2'b00;
    unique case (1'b1)
      size == SZ_BYTE: l = a;
      size == SZ_HALF: l = {a[1], 1'b0};
      default:         l = 2'b00;
    endcase
    return l;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      size == SZ_BYTE: be = 4'b0001 << lane;
      size == SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      size == SZ_WORD: be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d;
    unique case (1'b1)
      size == SZ_BYTE: w = {4{d[7:0]}};
      size == SZ_HALF: w = {2{d[15:0]}};
      default:         w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        uns
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    r  = sh;
    unique case (1'b1)
      size == SZ_BYTE: r = {{24{~uns & sh[7]}}, sh[7:0]};
      size == SZ_HALF: r = {{16{~uns & sh[15]}}, sh[15:0]};
      default:         r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-wide on-chip SRAM, four byte write enables, synchronous read.
// Read data holds until the next read so the response stays stable.
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with fixed wait states.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [LAT_CNT_W-1:0] LAST =
    (LATENCY == 0) ? '0 : LAT_CNT_W'(LATENCY - 1);

  state_e                 state;
  state_e                 state_nx;
  logic [LAT_CNT_W-1:0]   cnt;
  dmem_req_t              live;
  dmem_req_t              held;
  dmem_req_t              cur;
  logic                   accept;
  logic                   issue;
  logic                   cur_err;
  logic                   held_err;
  logic [1:0]             cur_lane;
  logic [1:0]             held_lane;
  logic [31:0]            sram_rdata;

  function automatic logic req_err(input dmem_req_t r);
    logic e;
    e = ((r.addr >> (ADDR_WIDTH + 2)) != '0)
      | (r.size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    e = e
      | ((r.size == SZ_HALF) & r.addr[0])
      | ((r.size == SZ_WORD) & (r.addr[1:0] != 2'b00));
`endif
    return e;
  endfunction

  assign live = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    size:  req_size,
    uns:   req_unsigned
  };

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // With no wait states the SRAM is driven straight from the request.
  assign issue = (LATENCY == 0)
               ? accept
               : ((state == ST_WAIT) && (cnt == LAST));
  assign cur   = (LATENCY == 0) ? live : held;

  assign cur_err   = req_err(cur);
  assign held_err  = req_err(held);
  assign cur_lane  = lane_of(cur.size, cur.addr[1:0]);
  assign held_lane = lane_of(held.size, held.addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      held  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_WAIT) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
      if (accept) held <= live;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == LAST) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  dmem_sram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .en    (issue & ~cur_err),
    .we    (cur.we),
    .be    (be_of(cur.size, cur_lane)),
    .addr  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata (wdata_of(cur.size, cur.wdata)),
    .rdata (sram_rdata)
  );

  always_comb begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (state == ST_RESP) begin
      resp_valid = 1'b1;
      resp_err   = held_err;
      if (!held_err && !held.we) begin
        resp_rdata = load_ext(sram_rdata, held.size,
                              held_lane, held.uns);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: four responders at LATENCY 1/0/7/3 with a
// scoreboard of expected responses fed by a behavioural memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic        resp_valid [4];
  logic        resp_ready [4];
  logic [31:0] resp_rdata [4];
  logic        resp_err [4];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [4][1024];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 3;
    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (L)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_err     (resp_err[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 7 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: range/size/alignment errors, byte-lane memory.
  task automatic model(input int i, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input bit u, output exp_t e);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          idx;
    e.err = (a[31:12] != 0) || (sz == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) e.err = 1'b1;
    if (sz == 2'b10 && a[1:0] != 0) e.err = 1'b1;
`endif
    e.rdata = '0;
    idx = int'(a[11:2]);
    if (e.err) return;
    w = mdl[i][idx];
    if (we) begin
      case (sz)
        2'b00: w[8*a[1:0] +: 8] = d[7:0];
        2'b01: w[16*a[1] +: 16] = d[15:0];
        default: w = d;
      endcase
      mdl[i][idx] = w;
    end else begin
      b = w[8*a[1:0] +: 8];
      h = w[16*a[1] +: 16];
      case (sz)
        2'b00: e.rdata = u ? {24'h0, b} : {{24{b[7]}}, b};
        2'b01: e.rdata = u ? {16'h0, h} : {{16{h[15]}}, h};
        default: e.rdata = w;
      endcase
    end
  endtask

  task automatic xact(input int i, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz,
                      input bit u, input int hold, input string tag);
    exp_t e;
    exp_t x;
    int   n;
    model(i, we, a, d, sz, u, e);
    sbq.push_back(e);
    chk({tag, ".ready"}, 32'(req_ready[i]), 32'd1);
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_size = sz;
    req_unsigned = u;
    req_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    n = 1;
    while (!resp_valid[i] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat_of(i) + 1));
    x = sbq.pop_front();
    chk({tag, ".rdata"}, resp_rdata[i], x.rdata);
    chk({tag, ".err"}, 32'(resp_err[i]), 32'(x.err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_v"}, 32'(resp_valid[i]), 32'd1);
      chk({tag, ".hold_d"}, resp_rdata[i], x.rdata);
      chk({tag, ".hold_r"}, 32'(req_ready[i]), 32'd0);
    end
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[i] = 1'b0;
    chk({tag, ".done_v"}, 32'(resp_valid[i]), 32'd0);
    chk({tag, ".done_r"}, 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      resp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst.ready", 32'(req_ready[i]), 32'd1);
      chk("rst.valid", 32'(resp_valid[i]), 32'd0);
      chk("rst.rdata", resp_rdata[i], 32'd0);
      chk("rst.err", 32'(resp_err[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word store/load at every latency under test.
    for (int i = 0; i < 4; i++) begin
      xact(i, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, "t1.st");
      xact(i, 0, 32'h10, 32'h0, 2'b10, 0, 0, "t1.ld");
    end

    xact(0, 0, 32'h13, 32'h0, 2'b00, 0, 0, "t2.lbs");
    xact(0, 0, 32'h13, 32'h0, 2'b00, 1, 0, "t2.lbu");
    xact(0, 0, 32'h12, 32'h0, 2'b01, 0, 0, "t2.lhs");
    xact(0, 0, 32'h10, 32'h0, 2'b01, 1, 0, "t2.lhu");
    xact(0, 1, 32'h11, 32'hFFFF_FF5A, 2'b00, 0, 0, "t3.sb");
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, "t3.lw");
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 5, "t4.hold");

    xact(0, 0, 32'h0000_1000, 32'h0, 2'b10, 0, 0, "t5.range");
    xact(0, 1, 32'h8000_0010, 32'h0BAD_0BAD, 2'b10, 0, 0, "t5.rst");
    xact(0, 0, 32'h10, 32'h0, 2'b11, 0, 0, "t5.size");
    xact(0, 1, 32'h12, 32'h1234_5678, 2'b10, 0, 0, "t5.mis");
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, "t5.chk");
    xact(1, 1, 32'h33, 32'h0000_ABCD, 2'b01, 0, 0, "t5.mish");
    xact(1, 0, 32'h30, 32'h0, 2'b10, 0, 0, "t5.chkh");

    // Reset during WAIT of a store drops the store.
    xact(3, 1, 32'h20, 32'h1111_1111, 2'b10, 0, 0, "t6.old");
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h2222_2222;
    req_size = 2'b10;
    req_valid[3] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    @(posedge clk);
    #1;
    chk("t6.wait_r", 32'(req_ready[3]), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6.rst_r", 32'(req_ready[3]), 32'd1);
    chk("t6.rst_v", 32'(resp_valid[3]), 32'd0);
    chk("t6.rst_d", resp_rdata[3], 32'd0);
    chk("t6.rst_e", 32'(resp_err[3]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    xact(3, 0, 32'h20, 32'h0, 2'b10, 0, 0, "t6.ld");

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
